// File: rtl/map_table_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : map_table_ctrl
//  Purpose  : Arbitrates rename/save/restore/revert requests to the physical
//             register map table and sequences checkpoint recovery.
//  Revision : 1.0
// ============================================================================
module map_table_ctrl #(
    parameter int CHECKPOINT_COLUMNS = 4,
    parameter int FLUSH_CYCLES       = 1,
    parameter int ARCH_W             = 5,
    parameter int PHYS_W             = 7,
    parameter int ROB_W              = 6
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  disp_valid_i,
    output logic                                  disp_ready_o,
    input  logic                                  disp_is_branch_i,
    input  logic                                  disp_writes_reg_i,
    input  logic [ARCH_W-1:0]                     disp_dest_arch_i,
    input  logic [PHYS_W-1:0]                     disp_new_phys_i,
    input  logic [ROB_W-1:0]                      disp_rob_index_i,
    input  logic                                  res_valid_i,
    input  logic                                  res_mispredict_i,
    input  logic [ROB_W-1:0]                      res_rob_index_i,
    input  logic [$clog2(CHECKPOINT_COLUMNS)-1:0] res_safe_column_i,
    output logic                                  res_restored_o,
    output logic                                  walk_req_o,
    input  logic                                  walk_valid_i,
    input  logic                                  walk_done_i,
    input  logic [ARCH_W-1:0]                     walk_arch_i,
    input  logic [PHYS_W-1:0]                     walk_safe_phys_i,
    input  logic [PHYS_W-1:0]                     walk_spec_phys_i,
    output logic [$clog2(CHECKPOINT_COLUMNS)-1:0] ckpt_column_o,
    output logic                                  prmt_rename_valid_o,
    output logic [ARCH_W-1:0]                     prmt_rename_dest_arch_o,
    output logic [PHYS_W-1:0]                     prmt_rename_dest_phys_o,
    output logic                                  prmt_revert_valid_o,
    output logic [ARCH_W-1:0]                     prmt_revert_arch_o,
    output logic [PHYS_W-1:0]                     prmt_revert_safe_phys_o,
    output logic [PHYS_W-1:0]                     prmt_revert_spec_phys_o,
    output logic                                  prmt_save_checkpoint_valid_o,
    output logic [ROB_W-1:0]                      prmt_save_checkpoint_rob_index_o,
    output logic                                  prmt_restore_checkpoint_valid_o,
    output logic                                  prmt_restore_checkpoint_speculate_failed_o,
    output logic [ROB_W-1:0]                      prmt_restore_checkpoint_rob_index_o,
    output logic [$clog2(CHECKPOINT_COLUMNS)-1:0] prmt_restore_checkpoint_safe_column_o,
    input  logic                                  prmt_restore_success_i,
    input  logic [$clog2(CHECKPOINT_COLUMNS)-1:0] prmt_save_safe_column_i
);

    localparam int LIVE_W  = $clog2(CHECKPOINT_COLUMNS);
    localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [LIVE_W-1:0]  c_LIVE_MAX = LIVE_W'(CHECKPOINT_COLUMNS - 1);
    localparam logic [FLUSH_W-1:0] c_FLUSH    = FLUSH_W'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        S_NORMAL      = 2'd0,
        S_SAVE_RENAME = 2'd1,
        S_WALK        = 2'd2,
        S_FLUSH       = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [LIVE_W-1:0]   live_cnt_q, live_cnt_d;
    logic [FLUSH_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [ARCH_W-1:0]   held_arch_q, held_arch_d;
    logic [PHYS_W-1:0]   held_phys_q, held_phys_d;
    logic                w_mis, w_ok, w_save;

    always_comb begin
        state_d     = state_q;
        live_cnt_d  = live_cnt_q;
        flush_cnt_d = flush_cnt_q;
        held_arch_d = held_arch_q;
        held_phys_d = held_phys_q;
        w_mis       = 1'b0;
        w_ok        = 1'b0;
        w_save      = 1'b0;
        disp_ready_o                               = 1'b0;
        res_restored_o                             = 1'b0;
        walk_req_o                                 = 1'b0;
        ckpt_column_o                              = '0;
        prmt_rename_valid_o                        = 1'b0;
        prmt_rename_dest_arch_o                    = '0;
        prmt_rename_dest_phys_o                    = '0;
        prmt_revert_valid_o                        = 1'b0;
        prmt_revert_arch_o                         = '0;
        prmt_revert_safe_phys_o                    = '0;
        prmt_revert_spec_phys_o                    = '0;
        prmt_save_checkpoint_valid_o               = 1'b0;
        prmt_save_checkpoint_rob_index_o           = '0;
        prmt_restore_checkpoint_valid_o            = 1'b0;
        prmt_restore_checkpoint_speculate_failed_o = 1'b0;
        prmt_restore_checkpoint_rob_index_o        = '0;
        prmt_restore_checkpoint_safe_column_o      = '0;

        if (!rst_i) begin
            w_ok  = res_valid_i & ~res_mispredict_i;
            // Mispredicts seen during recovery belong to already-squashed ops
            w_mis = res_valid_i & res_mispredict_i &
                    ((state_q == S_NORMAL) || (state_q == S_SAVE_RENAME));

            case (state_q)
                S_NORMAL: begin
                    if (!w_mis && disp_valid_i &&
                        !(disp_is_branch_i && (live_cnt_q == c_LIVE_MAX))) begin
                        if (disp_is_branch_i) begin
                            w_save       = 1'b1;
                            disp_ready_o = ~disp_writes_reg_i;
                            if (disp_writes_reg_i) begin
                                state_d     = S_SAVE_RENAME;
                                held_arch_d = disp_dest_arch_i;
                                held_phys_d = disp_new_phys_i;
                            end
                        end else begin
                            disp_ready_o = 1'b1;
                            if (disp_writes_reg_i) begin
                                prmt_rename_valid_o     = 1'b1;
                                prmt_rename_dest_arch_o = disp_dest_arch_i;
                                prmt_rename_dest_phys_o = disp_new_phys_i;
                            end
                        end
                    end
                end
                S_SAVE_RENAME: begin
                    if (!w_mis) begin
                        prmt_rename_valid_o     = 1'b1;
                        prmt_rename_dest_arch_o = held_arch_q;
                        prmt_rename_dest_phys_o = held_phys_q;
                        disp_ready_o            = 1'b1;
                        state_d                 = S_NORMAL;
                    end
                end
                S_WALK: begin
                    if (walk_valid_i) begin
                        prmt_revert_valid_o     = 1'b1;
                        prmt_revert_arch_o      = walk_arch_i;
                        prmt_revert_safe_phys_o = walk_safe_phys_i;
                        prmt_revert_spec_phys_o = walk_spec_phys_i;
                        if (walk_done_i) begin
                            state_d     = S_FLUSH;
                            flush_cnt_d = c_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt_q <= FLUSH_W'(1)) begin
                        state_d     = S_NORMAL;
                        flush_cnt_d = '0;
                    end else begin
                        flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
                    end
                end
                default: state_d = S_NORMAL;
            endcase

            if (w_save) begin
                prmt_save_checkpoint_valid_o     = 1'b1;
                prmt_save_checkpoint_rob_index_o = disp_rob_index_i;
                ckpt_column_o                    = prmt_save_safe_column_i;
            end

            if (w_mis || w_ok) begin
                prmt_restore_checkpoint_valid_o            = 1'b1;
                prmt_restore_checkpoint_speculate_failed_o = w_mis;
                prmt_restore_checkpoint_rob_index_o        = res_rob_index_i;
                prmt_restore_checkpoint_safe_column_o      = res_safe_column_i;
            end

            // A save and a freed checkpoint in the same cycle cancel out
            if (w_save && !w_ok) begin
                live_cnt_d = live_cnt_q + LIVE_W'(1);
            end else if (w_ok && !w_save && (live_cnt_q != '0)) begin
                live_cnt_d = live_cnt_q - LIVE_W'(1);
            end

            if (w_mis) begin
                live_cnt_d     = '0;
                flush_cnt_d    = c_FLUSH;
                res_restored_o = prmt_restore_success_i;
                walk_req_o     = ~prmt_restore_success_i;
                state_d        = prmt_restore_success_i ? S_FLUSH : S_WALK;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_NORMAL;
            live_cnt_q  <= '0;
            flush_cnt_q <= '0;
            held_arch_q <= '0;
            held_phys_q <= '0;
        end else begin
            state_q     <= state_d;
            live_cnt_q  <= live_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            held_arch_q <= held_arch_d;
            held_phys_q <= held_phys_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_map_table_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_map_table_ctrl
//  Purpose  : Directed and random checks of map_table_ctrl against a model.
//  Revision : 1.0
// ============================================================================
module tb_map_table_ctrl;

    localparam int COLS  = 4;
    localparam int FLUSH = 1;
    localparam int AW    = 5;
    localparam int PW    = 7;
    localparam int RW    = 6;
    localparam int CW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          disp_valid, disp_ready, disp_is_branch, disp_writes_reg;
    logic [AW-1:0] disp_dest_arch;
    logic [PW-1:0] disp_new_phys;
    logic [RW-1:0] disp_rob_index;
    logic          res_valid, res_mispredict, res_restored, walk_req;
    logic [RW-1:0] res_rob_index;
    logic [CW-1:0] res_safe_column;
    logic          walk_valid, walk_done;
    logic [AW-1:0] walk_arch;
    logic [PW-1:0] walk_safe_phys, walk_spec_phys;
    logic [CW-1:0] ckpt_column;
    logic          ren_v, rev_v, save_v, rst_v, rst_f;
    logic [AW-1:0] ren_arch, rev_arch;
    logic [PW-1:0] ren_phys, rev_safe, rev_spec;
    logic [RW-1:0] save_rob, rst_rob;
    logic [CW-1:0] rst_col;
    logic          restore_success;
    logic [CW-1:0] save_safe_col;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    map_table_ctrl #(
        .CHECKPOINT_COLUMNS(COLS), .FLUSH_CYCLES(FLUSH),
        .ARCH_W(AW), .PHYS_W(PW), .ROB_W(RW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .disp_valid_i(disp_valid), .disp_ready_o(disp_ready),
        .disp_is_branch_i(disp_is_branch), .disp_writes_reg_i(disp_writes_reg),
        .disp_dest_arch_i(disp_dest_arch), .disp_new_phys_i(disp_new_phys),
        .disp_rob_index_i(disp_rob_index),
        .res_valid_i(res_valid), .res_mispredict_i(res_mispredict),
        .res_rob_index_i(res_rob_index), .res_safe_column_i(res_safe_column),
        .res_restored_o(res_restored), .walk_req_o(walk_req),
        .walk_valid_i(walk_valid), .walk_done_i(walk_done),
        .walk_arch_i(walk_arch), .walk_safe_phys_i(walk_safe_phys),
        .walk_spec_phys_i(walk_spec_phys),
        .ckpt_column_o(ckpt_column),
        .prmt_rename_valid_o(ren_v), .prmt_rename_dest_arch_o(ren_arch),
        .prmt_rename_dest_phys_o(ren_phys),
        .prmt_revert_valid_o(rev_v), .prmt_revert_arch_o(rev_arch),
        .prmt_revert_safe_phys_o(rev_safe), .prmt_revert_spec_phys_o(rev_spec),
        .prmt_save_checkpoint_valid_o(save_v),
        .prmt_save_checkpoint_rob_index_o(save_rob),
        .prmt_restore_checkpoint_valid_o(rst_v),
        .prmt_restore_checkpoint_speculate_failed_o(rst_f),
        .prmt_restore_checkpoint_rob_index_o(rst_rob),
        .prmt_restore_checkpoint_safe_column_o(rst_col),
        .prmt_restore_success_i(restore_success),
        .prmt_save_safe_column_i(save_safe_col)
    );

    // Reference model: checkpoint count, held rename, recovery phase
    int            m_live;
    bit            m_pend;
    logic [AW-1:0] m_parch;
    logic [PW-1:0] m_pphys;
    bit            m_walk;
    int            m_flush;
    bit            x_mis, x_ok, x_save;

    logic                   e_ready;
    logic [AW+PW:0]         e_ren;
    logic [RW+CW:0]         e_save;
    logic [RW+CW+1:0]       e_rst;
    logic [AW+2*PW:0]       e_rev;
    logic [1:0]             e_rec;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_live = 0; m_pend = 0; m_walk = 0; m_flush = 0;
        m_parch = '0; m_pphys = '0;
    endtask

    task automatic model_expect();
        bit recov;
        recov  = m_walk || (m_flush > 0);
        x_mis  = res_valid && res_mispredict && !recov;
        x_ok   = res_valid && !res_mispredict;
        x_save = 1'b0;
        e_ready = 1'b0; e_ren = '0; e_save = '0; e_rev = '0;
        e_rst = (x_mis || x_ok) ? {1'b1, x_mis, res_rob_index, res_safe_column} : '0;
        e_rec = {x_mis && restore_success, x_mis && !restore_success};
        if (m_walk) begin
            if (walk_valid) e_rev = {1'b1, walk_arch, walk_safe_phys, walk_spec_phys};
        end else if (m_flush > 0) begin
            e_ready = 1'b0;
        end else if (m_pend) begin
            if (!x_mis) begin
                e_ren   = {1'b1, m_parch, m_pphys};
                e_ready = 1'b1;
            end
        end else if (!x_mis && disp_valid) begin
            if (disp_is_branch) begin
                if (m_live < COLS - 1) begin
                    x_save  = 1'b1;
                    e_save  = {1'b1, disp_rob_index, save_safe_col};
                    e_ready = !disp_writes_reg;
                end
            end else begin
                e_ready = 1'b1;
                if (disp_writes_reg) e_ren = {1'b1, disp_dest_arch, disp_new_phys};
            end
        end
    endtask

    task automatic model_update();
        if (x_mis) begin
            m_live = 0;
            m_pend = 0;
            if (restore_success) m_flush = FLUSH;
            else                 m_walk  = 1;
        end else begin
            m_live = m_live + int'(x_save);
            if (x_ok && m_live > 0) m_live--;
            if (m_pend) m_pend = 0;
            else if (x_save && disp_writes_reg) begin
                m_pend  = 1;
                m_parch = disp_dest_arch;
                m_pphys = disp_new_phys;
            end
            if (m_flush > 0) m_flush--;
            if (m_walk && walk_valid && walk_done) begin
                m_walk  = 0;
                m_flush = FLUSH;
            end
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic cycle();
        model_expect();
        chk("ready",   disp_ready, e_ready);
        chk("rename",  {ren_v, ren_arch, ren_phys}, e_ren);
        chk("save",    {save_v, save_rob, ckpt_column}, e_save);
        chk("restore", {rst_v, rst_f, rst_rob, rst_col}, e_rst);
        chk("revert",  {rev_v, rev_arch, rev_safe, rev_spec}, e_rev);
        chk("recover", {res_restored, walk_req}, e_rec);
        @(posedge clk);
        model_update();
        #1;
        chk("live", dut.live_cnt_q, m_live);
        @(negedge clk);
    endtask

    task automatic drive_disp(input logic v, input logic br, input logic wr,
                              input logic [AW-1:0] a, input logic [PW-1:0] p,
                              input logic [RW-1:0] rob, input logic [CW-1:0] col);
        disp_valid = v; disp_is_branch = br; disp_writes_reg = wr;
        disp_dest_arch = a; disp_new_phys = p; disp_rob_index = rob; save_safe_col = col;
    endtask

    task automatic drive_res(input logic v, input logic mis, input logic [RW-1:0] rob,
                             input logic [CW-1:0] col, input logic succ);
        res_valid = v; res_mispredict = mis; res_rob_index = rob;
        res_safe_column = col; restore_success = succ;
    endtask

    task automatic drive_walk(input logic v, input logic done, input logic [AW-1:0] a,
                              input logic [PW-1:0] s, input logic [PW-1:0] p);
        walk_valid = v; walk_done = done; walk_arch = a; walk_safe_phys = s; walk_spec_phys = p;
    endtask

    task automatic idle();
        drive_disp(0, 0, 0, '0, '0, '0, '0);
        drive_res(0, 0, '0, '0, 0);
        drive_walk(0, 0, '0, '0, '0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        // Outputs stay quiet under reset even with active inputs
        drive_disp(1, 0, 1, 5'd3, 7'd9, 6'd1, 2'd0);
        drive_res(1, 0, 6'd2, 2'd1, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",   disp_ready, 0);
        chk("rst_rename",  ren_v, 0);
        chk("rst_restore", rst_v, 0);
        chk("rst_live",    dut.live_cnt_q, 0);
        rst = 1'b0;
        idle();

        // Plain ALU op renames in the same cycle
        drive_disp(1, 0, 1, 5'd5, 7'd40, 6'd1, 2'd0);
        settle();
        chk("alu_rename", {ren_v, ren_arch, ren_phys}, {1'b1, 5'd5, 7'd40});
        chk("alu_nosave", save_v, 0);
        cycle();

        // Branch with dest splits into save then rename
        drive_disp(1, 1, 1, 5'd1, 7'd33, 6'd7, 2'd1);
        settle();
        chk("split_save", {save_v, save_rob, disp_ready}, {1'b1, 6'd7, 1'b0});
        cycle();
        settle();
        chk("split_rename", {ren_v, ren_arch, ren_phys, disp_ready}, {1'b1, 5'd1, 7'd33, 1'b1});
        cycle();
        chk("split_live", dut.live_cnt_q, 1);

        // Fill checkpoints, then a 4th branch stalls until a correct resolve
        drive_disp(1, 1, 0, '0, '0, 6'd8, 2'd2);  settle(); cycle();
        drive_disp(1, 1, 0, '0, '0, 6'd9, 2'd3);  settle(); cycle();
        drive_disp(1, 1, 0, '0, '0, 6'd10, 2'd0);
        settle();
        chk("full_stall", {disp_ready, save_v}, 2'b00);
        cycle();
        drive_res(1, 0, 6'd7, 2'd1, 0);
        settle();
        chk("full_resolve", {disp_ready, rst_v, rst_f}, 3'b010);
        cycle();
        chk("full_live_dec", dut.live_cnt_q, 2);
        drive_res(0, 0, '0, '0, 0);
        settle();
        chk("full_save", {save_v, disp_ready}, 2'b11);
        cycle();

        // Mispredict recovered by checkpoint
        drive_disp(1, 0, 1, 5'd6, 7'd50, 6'd11, 2'd0);
        drive_res(1, 1, 6'd8, 2'd2, 1);
        settle();
        chk("mis_ok", {res_restored, walk_req, rst_f, disp_ready, ren_v}, 5'b10100);
        cycle();
        drive_res(0, 0, '0, '0, 0);
        settle();
        chk("flush_block", disp_ready, 0);
        cycle();
        settle(); cycle();

        // Mispredict that misses: ROB walk of three entries with a gap
        drive_disp(1, 1, 0, '0, '0, 6'd20, 2'd1); settle(); cycle();
        drive_disp(1, 0, 1, 5'd2, 7'd60, 6'd21, 2'd0);
        drive_res(1, 1, 6'd20, 2'd1, 0);
        settle();
        chk("mis_walkreq", {walk_req, res_restored}, 2'b10);
        cycle();
        drive_res(0, 0, '0, '0, 0);
        drive_walk(1, 0, 5'd2, 7'd12, 7'd60); settle(); cycle();
        drive_walk(0, 0, '0, '0, '0);         settle(); cycle();
        drive_walk(1, 0, 5'd3, 7'd13, 7'd61); settle(); cycle();
        drive_walk(1, 1, 5'd4, 7'd14, 7'd62);
        settle();
        chk("walk_last", {rev_v, rev_arch, rev_safe, rev_spec, disp_ready},
            {1'b1, 5'd4, 7'd14, 7'd62, 1'b0});
        cycle();
        drive_walk(0, 0, '0, '0, '0);
        settle(); cycle();
        settle();
        chk("walk_back_normal", disp_ready, 1);
        cycle();

        // Correct resolve alongside a save leaves the count unchanged
        drive_disp(1, 1, 0, '0, '0, 6'd30, 2'd2); settle(); cycle();
        drive_disp(1, 1, 0, '0, '0, 6'd31, 2'd3);
        drive_res(1, 0, 6'd30, 2'd2, 0);
        settle();
        chk("save_and_restore", {save_v, rst_v, rst_f}, 3'b110);
        cycle();
        chk("net_live", dut.live_cnt_q, 1);

        // Mispredict while the split rename is pending drops it
        drive_res(0, 0, '0, '0, 0);
        drive_disp(1, 1, 1, 5'd9, 7'd70, 6'd32, 2'd0); settle(); cycle();
        drive_res(1, 1, 6'd31, 2'd3, 1);
        settle();
        chk("pend_drop", {ren_v, disp_ready, res_restored}, 3'b001);
        cycle();
        idle(); settle(); cycle();

        for (int i = 0; i < 500; i++) begin
            drive_disp($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
                       $urandom_range(0, 9) < 6, AW'($urandom), PW'($urandom),
                       RW'($urandom), CW'($urandom));
            drive_res($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
                      RW'($urandom), CW'($urandom), $urandom_range(0, 1) == 1);
            drive_walk($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                       AW'($urandom), PW'($urandom), PW'($urandom));
            settle();
            cycle();
        end

        // Asynchronous reset while a split rename is pending
        rst = 1'b1; idle(); #1; rst = 1'b0;
        @(negedge clk);
        model_reset();
        drive_disp(1, 1, 0, '0, '0, 6'd40, 2'd0); settle(); cycle();
        drive_disp(1, 1, 1, 5'd7, 7'd77, 6'd41, 2'd1); settle(); cycle();
        rst = 1'b1;
        #1;
        chk("async_live", dut.live_cnt_q, 0);
        chk("async_ready", {disp_ready, ren_v}, 2'b00);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        settle();
        chk("latch_discarded", {ren_v, save_v, disp_ready}, 3'b010);
        cycle();
        idle(); settle(); cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
